// File: rtl/vram_sys_arb_if.sv
// Bundle of the CPU, Earthrise and vram system-side signals seen by the arbiter.
// The arbiter uses the slave view; the requesters/vram side use the master view.
interface vram_sys_arb_if #(
  parameter int WORD  = 32,
  parameter int BYTE  = 8,
  parameter int ADDRW = 14
);
  localparam int NBE = WORD / BYTE;

  // CPU side
  logic             cpu_req;
  logic             cpu_we;
  logic [ADDRW-1:0] cpu_addr;
  logic [NBE-1:0]   cpu_be;
  logic [WORD-1:0]  cpu_din;
  logic             cpu_ack;
  logic             cpu_rvalid;
  logic [WORD-1:0]  cpu_dout;

  // Earthrise side (write-only)
  logic             er_req;
  logic [ADDRW-1:0] er_addr;
  logic [WORD-1:0]  er_wmask;
  logic [WORD-1:0]  er_din;
  logic             er_ack;

  // vram system port
  logic [ADDRW-1:0] vram_addr;
  logic [WORD-1:0]  vram_wmask;
  logic [WORD-1:0]  vram_din;
  logic [WORD-1:0]  vram_dout;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_be, cpu_din,
    output cpu_ack, cpu_rvalid, cpu_dout,
    input  er_req, er_addr, er_wmask, er_din,
    output er_ack,
    output vram_addr, vram_wmask, vram_din,
    input  vram_dout
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_be, cpu_din,
    input  cpu_ack, cpu_rvalid, cpu_dout,
    output er_req, er_addr, er_wmask, er_din,
    input  er_ack,
    input  vram_addr, vram_wmask, vram_din,
    output vram_dout
  );
endinterface

// File: rtl/vram_sys_arb.sv
// vram system-port arbiter: CPU (read/write) vs Earthrise (write-only).
// One access per cycle, combinational grant. CPU wins ties unless Earthrise
// has been denied ER_STARVE consecutive cycles. CPU reads are tracked through
// an RD_LAT-deep valid pipe so read data is flagged when vram returns it.
module vram_sys_arb #(
  parameter int WORD      = 32,
  parameter int BYTE      = 8,
  parameter int ADDRW     = 14,
  parameter int RD_LAT    = 1,
  parameter int ER_STARVE = 4
) (
  input logic         clk,
  input logic         rst,
  vram_sys_arb_if.slave bus
);
  localparam int NBE   = WORD / BYTE;
  localparam int CNT_W = (ER_STARVE < 1) ? 1 : $clog2(ER_STARVE + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(ER_STARVE);

  // Expand per-byte enables into a per-bit write mask.
  function automatic logic [WORD-1:0] be_to_mask(input logic [NBE-1:0] be);
    logic [WORD-1:0] m;
    m = '0;
    for (int i = 0; i < WORD; i++) begin
      m[i] = be[i / BYTE];
    end
    return m;
  endfunction

  logic              hold_r;       // high on the first cycle after reset
  logic [CNT_W-1:0]  starve_r;
  logic [CNT_W-1:0]  starve_nxt_s;
  logic [RD_LAT-1:0] rd_pipe_r;
  logic              blocked_s;
  logic              starved_s;
  logic              cpu_gnt_s;
  logic              er_gnt_s;
  logic              rd_issue_s;
  logic [ADDRW-1:0]  vram_addr_s;
  logic [WORD-1:0]   vram_wmask_s;
  logic [WORD-1:0]   vram_din_s;

  // Grant decision: block during reset and the cycle after, CPU priority unless starved.
  always_comb begin
    blocked_s  = rst | hold_r;
    starved_s  = (starve_r == STARVE_MAX);
    cpu_gnt_s  = 1'b0;
    er_gnt_s   = 1'b0;
    if (blocked_s) begin
      cpu_gnt_s = 1'b0;
      er_gnt_s  = 1'b0;
    end else if (bus.cpu_req && bus.er_req) begin
      cpu_gnt_s = ~starved_s;
      er_gnt_s  = starved_s;
    end else begin
      cpu_gnt_s = bus.cpu_req;
      er_gnt_s  = bus.er_req;
    end
    rd_issue_s = cpu_gnt_s & ~bus.cpu_we;
  end

  // Drive the vram port from whichever requester holds the grant.
  always_comb begin
    vram_addr_s  = '0;
    vram_wmask_s = '0;
    vram_din_s   = '0;
    if (cpu_gnt_s) begin
      vram_addr_s = bus.cpu_addr;
      if (bus.cpu_we) begin
        vram_wmask_s = be_to_mask(bus.cpu_be);
        vram_din_s   = bus.cpu_din;
      end else begin
        vram_wmask_s = '0;
        vram_din_s   = '0;
      end
    end else if (er_gnt_s) begin
      vram_addr_s  = bus.er_addr;
      vram_wmask_s = bus.er_wmask;
      vram_din_s   = bus.er_din;
    end else begin
      vram_addr_s  = '0;
      vram_wmask_s = '0;
      vram_din_s   = '0;
    end
  end

  // Next starvation count: grow while Earthrise waits, saturate, clear otherwise.
  always_comb begin
    starve_nxt_s = '0;
    if (bus.er_req && !er_gnt_s) begin
      if (starved_s) begin
        starve_nxt_s = starve_r;
      end else begin
        starve_nxt_s = starve_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      starve_nxt_s = '0;
    end
  end

  // Sequential state: post-reset hold flag, starvation counter, read valid pipe.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_r    <= 1'b1;
      starve_r  <= '0;
      rd_pipe_r <= '0;
    end else begin
      hold_r       <= 1'b0;
      starve_r     <= starve_nxt_s;
      rd_pipe_r[0] <= rd_issue_s;
      for (int i = 1; i < RD_LAT; i++) begin
        rd_pipe_r[i] <= rd_pipe_r[i-1];
      end
    end
  end

  assign bus.cpu_ack    = cpu_gnt_s;
  assign bus.er_ack     = er_gnt_s;
  assign bus.vram_addr  = vram_addr_s;
  assign bus.vram_wmask = vram_wmask_s;
  assign bus.vram_din   = vram_din_s;
  // A read in flight when reset arrives must never report valid data.
  assign bus.cpu_rvalid = rd_pipe_r[RD_LAT-1] & ~rst;
  assign bus.cpu_dout   = bus.vram_dout;
endmodule
